pushbutton_conditioner: RTL and testbench

//   Front end for the uP input port. Synchronises, debounces and edge-detects the raw board

---
 rtl/pushbutton_conditioner.sv | 110 +++++++++++
 tb/tb_pushbutton_conditioner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_conditioner
// Description : Front end for the uP input port. Synchronises, debounces and
//               edge-detects the raw board pushbuttons, then latches presses
//               until the CPU acknowledges them with rd_ack_i.
// Ports       :
//   clk           system clock (same clock as the uP)
//   reset         asynchronous, active-high reset
//   btn_raw_i     raw asynchronous pushbutton levels, 1 = pressed
//   rd_ack_i      one-cycle strobe: CPU has consumed btn_sticky_o
//   btn_level_o   debounced stable level per button
//   btn_press_o   one-cycle pulse per button on each accepted 0->1 change
//   btn_sticky_o  latched presses presented to the uP input port
//   pending_o     OR-reduction of btn_sticky_o
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit STICKY          = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw_i,
  input  logic             rd_ack_i,
  output logic [WIDTH-1:0] btn_level_o,
  output logic [WIDTH-1:0] btn_press_o,
  output logic [WIDTH-1:0] btn_sticky_o,
  output logic             pending_o
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser; only sync2_q is ever looked at downstream.
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q,   cnt_d;

  // Per-bit debounce: the counter only advances while the synchronised input
  // disagrees with the accepted level, so any return to agreement discards a
  // partial count. The press pulse is produced in the same next-state logic
  // so it lands on the same edge as the 0->1 level change.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == C_CNT_MAX) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (STICKY) begin : g_sticky
      logic [WIDTH-1:0] sticky_q, sticky_d;

      // Set has priority over the acknowledge so a press arriving in the
      // same cycle as rd_ack_i survives into the next read.
      always_comb begin
        sticky_d = (sticky_q & ~{WIDTH{rd_ack_i}}) | press_d;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sticky_q <= '0;
        end else begin
          sticky_q <= sticky_d;
        end
      end

      assign btn_sticky_o = sticky_q;
    end else begin : g_level
      assign btn_sticky_o = level_q;
    end
  endgenerate

  assign btn_level_o = level_q;
  assign btn_press_o = press_q;
  assign pending_o   = |btn_sticky_o;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pushbutton_conditioner
// Description : Directed self-checking bench for pushbutton_conditioner with
//               WIDTH=4, DEBOUNCE_CYCLES=4. A second instance with STICKY=0
//               shares the inputs. Inputs change just after a falling edge
//               and outputs are sampled on falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic       rd_ack;
  logic [3:0] btn_level, btn_press, btn_sticky;
  logic       pending;
  logic [3:0] btn_level0, btn_press0, btn_sticky0;
  logic       pending0;

  int checks;
  int failures;

  pushbutton_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .STICKY(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw_i    (btn_raw),
    .rd_ack_i     (rd_ack),
    .btn_level_o  (btn_level),
    .btn_press_o  (btn_press),
    .btn_sticky_o (btn_sticky),
    .pending_o    (pending)
  );

  pushbutton_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .STICKY(1'b0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .btn_raw_i    (btn_raw),
    .rd_ack_i     (rd_ack),
    .btn_level_o  (btn_level0),
    .btn_press_o  (btn_press0),
    .btn_sticky_o (btn_sticky0),
    .pending_o    (pending0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 4'b1111;
    rd_ack  = 1'b0;
    #3;
    checks++;
    if ({btn_level, btn_press, btn_sticky, pending} !== 13'd0) begin
      failures++;
      $display("FAIL reset_before_clk got=%b exp=0", {btn_level, btn_press, btn_sticky, pending});
    end
    step(3);
    checks++;
    if ({btn_level, btn_press, btn_sticky, pending} !== 13'd0) begin
      failures++;
      $display("FAIL reset_held got=%b exp=0", {btn_level, btn_press, btn_sticky, pending});
    end
    btn_raw = 4'b0000;
    reset   = 1'b0;
    step(8);
    checks++;
    if ({btn_level, btn_press, btn_sticky, pending} !== 13'd0) begin
      failures++;
      $display("FAIL reset_released_idle got=%b exp=0", {btn_level, btn_press, btn_sticky, pending});
    end
  endtask

  // Raw change before edge k; edge k+5 is the 6th falling edge afterwards.
  task automatic test_press();
    btn_raw = 4'b0001;
    step(5);
    checks++;
    if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
      failures++;
      $display("FAIL press_early level=%b press=%b exp=0000/0000", btn_level, btn_press);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b0001 || btn_press !== 4'b0001 || btn_sticky !== 4'b0001 || pending !== 1'b1) begin
      failures++;
      $display("FAIL press_accept level=%b press=%b sticky=%b pend=%b exp=0001/0001/0001/1",
               btn_level, btn_press, btn_sticky, pending);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b0001 || btn_press !== 4'b0000 || btn_sticky !== 4'b0001 || pending !== 1'b1) begin
      failures++;
      $display("FAIL press_one_cycle level=%b press=%b sticky=%b pend=%b exp=0001/0000/0001/1",
               btn_level, btn_press, btn_sticky, pending);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    btn_raw = 4'b0101;
    step(3);
    btn_raw = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (btn_level[2] !== 1'b0 || btn_press[2] !== 1'b0 || btn_sticky[2] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL glitch_bit2 bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (btn_level !== 4'b0001 || btn_sticky !== 4'b0001) begin
      failures++;
      $display("FAIL glitch_end level=%b sticky=%b exp=0001/0001", btn_level, btn_sticky);
    end
  endtask

  task automatic test_ack();
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    checks++;
    if (btn_sticky !== 4'b0000 || pending !== 1'b0) begin
      failures++;
      $display("FAIL ack_clear sticky=%b pend=%b exp=0000/0", btn_sticky, pending);
    end
    // Bit-1 press pulse lands on edge k+5; rd_ack is high for that same edge.
    btn_raw = 4'b0011;
    step(5);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    checks++;
    if (btn_press !== 4'b0010 || btn_sticky !== 4'b0010) begin
      failures++;
      $display("FAIL ack_coincident press=%b sticky=%b exp=0010/0010", btn_press, btn_sticky);
    end
    step(1);
    checks++;
    if (btn_sticky !== 4'b0010 || pending !== 1'b1) begin
      failures++;
      $display("FAIL ack_set_wins sticky=%b pend=%b exp=0010/1", btn_sticky, pending);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    checks++;
    if (btn_sticky !== 4'b0000 || pending !== 1'b0) begin
      failures++;
      $display("FAIL ack_clear2 sticky=%b pend=%b exp=0000/0", btn_sticky, pending);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    int first_at;
    pulses   = 0;
    first_at = -1;
    for (int c = 0; c < 12; c++) begin
      btn_raw[3] = (((c / 2) % 2) == 0);
      step(1);
      if (btn_press[3] === 1'b1) pulses++;
    end
    btn_raw[3] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step(1);
      if (btn_press[3] === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = n;
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (first_at != 6) begin
      failures++;
      $display("FAIL bounce_latency got=%0d exp=6", first_at);
    end
    checks++;
    if (btn_level !== 4'b1011 || btn_sticky !== 4'b1000) begin
      failures++;
      $display("FAIL bounce_end level=%b sticky=%b exp=1011/1000", btn_level, btn_sticky);
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 4'b0001;
    step(10);
    btn_raw = 4'b0011;
    step(4);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_sticky, pending} !== 13'd0 ||
        {btn_level0, btn_sticky0, pending0} !== 9'd0) begin
      failures++;
      $display("FAIL midreset_async got=%b/%b exp=0/0",
               {btn_level, btn_press, btn_sticky, pending}, {btn_level0, btn_sticky0, pending0});
    end
    step(2);
    reset = 1'b0;
    step(5);
    checks++;
    if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_early level=%b press=%b exp=0000/0000", btn_level, btn_press);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b0011 || btn_press !== 4'b0011 || btn_sticky !== 4'b0011) begin
      failures++;
      $display("FAIL midreset_repress level=%b press=%b sticky=%b exp=0011/0011/0011",
               btn_level, btn_press, btn_sticky);
    end
  endtask

  task automatic test_sticky0();
    checks++;
    if (btn_sticky0 !== 4'b0011 || pending0 !== 1'b1) begin
      failures++;
      $display("FAIL s0_track sticky=%b pend=%b exp=0011/1", btn_sticky0, pending0);
    end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    checks++;
    if (btn_sticky0 !== 4'b0011 || pending0 !== 1'b1) begin
      failures++;
      $display("FAIL s0_ack_ignored sticky=%b pend=%b exp=0011/1", btn_sticky0, pending0);
    end
    btn_raw = 4'b0000;
    step(5);
    checks++;
    if (btn_sticky0 !== 4'b0011) begin
      failures++;
      $display("FAIL s0_release_early sticky=%b exp=0011", btn_sticky0);
    end
    step(1);
    checks++;
    if (btn_sticky0 !== 4'b0000 || pending0 !== 1'b0 || btn_press0 !== 4'b0000) begin
      failures++;
      $display("FAIL s0_release sticky=%b pend=%b press=%b exp=0000/0/0000",
               btn_sticky0, pending0, btn_press0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_press();
    test_glitch();
    test_ack();
    test_bounce();
    test_reset_mid();
    test_sticky0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
